// File: rtl/ifft_seq_ctrl.sv
// Sequencer for the 16-point radix-2 IFFT: bit-reversed load, 4x8 butterfly issue, natural-order unload.
// Optional IFFT_OVERRUN_EN adds a sticky 'overrun' flag for in_valid seen while the core is busy computing/unloading.
module ifft_seq_ctrl #(
  parameter int NUM_STAGES     = 4,
  parameter int BFLY_PER_STAGE = 8,
  parameter int BFLY_LAT       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic       bfly_en,
  output logic [1:0] stage,
  output logic [2:0] bfly_idx,
  output logic       bfly_wb_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] rd_addr,
  output logic       out_last,
  output logic       busy,
  output logic       frame_done
`ifdef IFFT_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

  state_t              state, state_nxt;
  logic [3:0]          load_cnt, load_cnt_nxt;
  logic [3:0]          out_cnt, out_cnt_nxt;
  logic [2:0]          bfly_cnt, bfly_cnt_nxt;
  logic [2:0]          drain_cnt, drain_cnt_nxt;
  logic [1:0]          stage_cnt, stage_cnt_nxt;
  logic                done_q, done_nxt;
  logic [BFLY_LAT-1:0] wb_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      out_cnt   <= '0;
      bfly_cnt  <= '0;
      drain_cnt <= '0;
      stage_cnt <= '0;
      done_q    <= 1'b0;
      wb_sr     <= '0;
    end else begin
      state     <= state_nxt;
      load_cnt  <= load_cnt_nxt;
      out_cnt   <= out_cnt_nxt;
      bfly_cnt  <= bfly_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      stage_cnt <= stage_cnt_nxt;
      done_q    <= done_nxt;
      // Write-back strobe is a pure delay of the issue strobe, independent of state.
      wb_sr     <= BFLY_LAT'({wb_sr, bfly_en});
    end
  end

  always_comb begin
    state_nxt     = state;
    load_cnt_nxt  = load_cnt;
    out_cnt_nxt   = out_cnt;
    bfly_cnt_nxt  = bfly_cnt;
    drain_cnt_nxt = drain_cnt;
    stage_cnt_nxt = stage_cnt;
    done_nxt      = 1'b0;
    in_ready      = 1'b0;
    wr_en         = 1'b0;
    bfly_en       = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    rd_addr       = '0;
    wr_addr       = {load_cnt[0], load_cnt[1], load_cnt[2], load_cnt[3]};
    stage         = stage_cnt;
    bfly_idx      = bfly_cnt;
    busy          = (state != IDLE);
    frame_done    = done_q;
    bfly_wb_en    = wb_sr[BFLY_LAT-1];

    case (state)
      IDLE: begin
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        if (in_valid) begin
          load_cnt_nxt = load_cnt + 4'd1;
          if (load_cnt == 4'hF) state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        bfly_en      = 1'b1;
        bfly_cnt_nxt = bfly_cnt + 3'd1;
        if (bfly_cnt == 3'(BFLY_PER_STAGE - 1)) begin
          bfly_cnt_nxt = '0;
          state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == 3'(BFLY_LAT - 1)) begin
          drain_cnt_nxt = '0;
          if (stage_cnt == 2'(NUM_STAGES - 1)) begin
            stage_cnt_nxt = '0;
            state_nxt     = UNLOAD;
          end else begin
            stage_cnt_nxt = stage_cnt + 2'd1;
            state_nxt     = COMPUTE;
          end
        end else begin
          drain_cnt_nxt = drain_cnt + 3'd1;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        rd_addr   = out_cnt;
        out_last  = (out_cnt == 4'hF);
        if (out_ready) begin
          out_cnt_nxt = out_cnt + 4'd1;
          if (out_cnt == 4'hF) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IFFT_OVERRUN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (state == IDLE && state_nxt == LOAD) begin
      overrun <= 1'b0;
    end else if (in_valid && (state inside {COMPUTE, DRAIN, UNLOAD})) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifft_seq_ctrl.sv
// Scoreboard bench for ifft_seq_ctrl: driver pushes per-frame expectations, negedge monitor pops and compares.
module tb_ifft_seq_ctrl;
  localparam int LAT   = 2;
  localparam int LAT5  = 5;
  localparam int SPAN  = 4 * (8 + LAT);
  localparam int SPAN5 = 4 * (8 + LAT5);
  localparam int NF    = 7;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic in_ready, wr_en, bfly_en, bfly_wb_en, out_valid, out_last, busy, frame_done;
  logic [3:0] wr_addr, rd_addr;
  logic [1:0] stage;
  logic [2:0] bfly_idx;
  logic in_ready_5, wr_en_5, bfly_en_5, bfly_wb_en_5, out_valid_5, out_last_5, busy_5, frame_done_5;
  logic [3:0] wr_addr_5, rd_addr_5;
  logic [1:0] stage_5;
  logic [2:0] bfly_idx_5;
`ifdef IFFT_OVERRUN_EN
  logic overrun, overrun_5;
`endif

  always #5 clk = ~clk;

  ifft_seq_ctrl #(.BFLY_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .bfly_en(bfly_en), .stage(stage), .bfly_idx(bfly_idx),
    .bfly_wb_en(bfly_wb_en), .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr(rd_addr), .out_last(out_last), .busy(busy), .frame_done(frame_done)
`ifdef IFFT_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  ifft_seq_ctrl #(.BFLY_LAT(LAT5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_5), .wr_en(wr_en_5),
    .wr_addr(wr_addr_5), .bfly_en(bfly_en_5), .stage(stage_5), .bfly_idx(bfly_idx_5),
    .bfly_wb_en(bfly_wb_en_5), .out_valid(out_valid_5), .out_ready(out_ready),
    .rd_addr(rd_addr_5), .out_last(out_last_5), .busy(busy_5), .frame_done(frame_done_5)
`ifdef IFFT_OVERRUN_EN
    , .overrun(overrun_5)
`endif
  );

  int wr_q[$];
  int bf_q[$];
  int out_q[$];
  int wbt_q[$];
  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int hs_n = 0;
  int timeouts = 0;
  bit finish_req = 1'b0;

  function automatic int bitrev4(int i);
    int r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 16; i++) wr_q.push_back(bitrev4(i));
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 8; b++) bf_q.push_back(s * 8 + b);
    for (int i = 0; i < 16; i++) out_q.push_back(i);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model
  int cyc = 0;
  int last_hs = -100;
  int c0 = -1, c05 = -1;
  int load_n = 0;
  bit idle = 1'b1, pl = 1'b0, ov_exp = 1'b0;

  always @(negedge clk) begin
    bit fd_exp, beat, last_beat;
    int e, t;
    cyc++;
    if (finish_req) begin
      chk("no_timeout", timeouts, 0);
      chk("wr_q_empty", wr_q.size(), 0);
      chk("bf_q_empty", bf_q.size(), 0);
      chk("out_q_empty", out_q.size(), 0);
      chk("wb_q_empty", wbt_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (!rst) begin
      chk("reset_outputs", int'({in_ready, wr_en, wr_addr, bfly_en, stage, bfly_idx, bfly_wb_en,
                                 out_valid, rd_addr, out_last, busy, frame_done}), 0);
      chk("reset_outputs_lat5", int'({busy_5, bfly_en_5, bfly_wb_en_5, out_valid_5}), 0);
`ifdef IFFT_OVERRUN_EN
      chk("reset_overrun", overrun, 0);
`endif
      idle = 1'b1; pl = 1'b0; ov_exp = 1'b0; load_n = 0; hs_n = 0;
      last_hs = -100; c0 = -1; c05 = -1;
    end else begin
      fd_exp = (cyc == last_hs + 1);
      if (fd_exp) begin idle = 1'b1; pl = 1'b0; end
      chk("busy", busy, !idle);
      chk("in_ready", in_ready, !idle && !pl);
      beat = in_valid && !idle && !pl;
      chk("wr_en", wr_en, beat);
      if (fd_exp || frame_done) begin
        chk("frame_done", frame_done, fd_exp);
        if (fd_exp) chk("fd_out_valid_low", out_valid, 0);
      end
      if (fd_exp) begin frames_done++; hs_n = 0; end

      last_beat = 1'b0;
      if (beat) begin
        load_n++;
        if (load_n == 16) begin last_beat = 1'b1; load_n = 0; end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin e = wr_q.pop_front(); chk("wr_addr", wr_addr, e); end
      end

      if (bfly_wb_en) begin
        if (wbt_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin t = wbt_q.pop_front(); chk("wb_lag", cyc - t, LAT); end
      end
      if (bfly_en) begin
        wbt_q.push_back(cyc);
        if (bf_q.size() == 0) chk("bfly_unexpected", 1, 0);
        else begin e = bf_q.pop_front(); chk("bfly_stage_idx", stage * 8 + bfly_idx, e); end
      end

      if (c0 < 0 && bfly_en) c0 = cyc;
      if (c0 >= 0) begin
        if (cyc - c0 == SPAN) begin chk("span_then_unload", out_valid, 1); c0 = -1; end
        else chk("bfly_issue_window", bfly_en, ((cyc - c0) % (8 + LAT)) < 8);
      end
      if (c05 < 0 && bfly_en_5) c05 = cyc;
      if (c05 >= 0) begin
        if (cyc - c05 == SPAN5) begin chk("span_then_unload_lat5", out_valid_5, 1); c05 = -1; end
        else chk("bfly_issue_window_lat5", bfly_en_5, ((cyc - c05) % (8 + LAT5)) < 8);
      end

      if (out_valid) begin
        if (out_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          e = out_q[0];
          chk("rd_addr", rd_addr, e);
          chk("out_last", out_last, e == 15);
          if (out_ready) begin
            void'(out_q.pop_front());
            hs_n++;
            if (e == 15) last_hs = cyc;
          end
        end
      end

`ifdef IFFT_OVERRUN_EN
      chk("overrun", overrun, ov_exp);
      if (idle && in_valid) ov_exp = 1'b0;
      else if (pl && in_valid) ov_exp = 1'b1;
`endif
      if (idle && in_valid) idle = 1'b0;
      if (last_beat) pl = 1'b1;
    end
  end

  // Driver
  initial begin
    int budget;
    int f0;
    bit tog;
    bit did_rst;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; did_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    for (int f = 0; f < NF; f++) begin
      push_frame();
      f0 = frames_done;
      budget = 2000;
      tog = 1'b1;
      while (frames_done == f0 && budget > 0) begin
        @(posedge clk);
        #1;
        in_valid = (f % 2 == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
        if (f == NF - 1 && (out_valid || hs_n > 0)) in_valid = 1'b0;
        case (f % 3)
          0: out_ready = $urandom_range(0, 1) == 1;
          1: out_ready = tog;
          default: out_ready = 1'b1;
        endcase
        tog = !tog;
        budget--;
        if (f == 3 && !did_rst && hs_n == 5 && out_valid) begin
          did_rst = 1'b1;
          #1 rst = 1'b0;
          @(posedge clk);
          @(posedge clk);
          #1;
          wr_q.delete(); bf_q.delete(); out_q.delete(); wbt_q.delete();
          push_frame();
          in_valid = 1'b1;
          #1 rst = 1'b1;
        end
      end
      if (budget == 0) begin
        timeouts++;
        f = NF;
      end
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    finish_req = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL watchdog: monitor did not finish, got 0, expected 1");
    $fatal(1);
  end
endmodule

// File: doc/ifft_seq_ctrl.md
Name: ifft_seq_ctrl

Overview:
Sequencer for the 16-point fixed-point IFFT core. It accepts 16 input samples and writes them into the working buffer in bit-reversed order. It then issues the radix-2 butterflies for the 4 stages, 8 per stage, and finally streams the 16 results out in natural order with a valid/ready handshake. It sits between the upstream modulation mapper and the cyclic-prefix stage, and drives the address, enable and stage-select inputs of the butterfly datapath and the sample buffer.

Parameters:
NUM_STAGES, 4, number of radix-2 stages (log2 of 16); fixed, not intended for override.
BFLY_PER_STAGE, 8, butterfly operations issued per stage.
BFLY_LAT, 2, butterfly pipeline latency in cycles, from bfly_en to write-back; legal range 1..7.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream sample valid
in_ready  output  1  controller accepts a sample this cycle
wr_en  output  1  buffer write strobe for the input sample
wr_addr  output  4  buffer write address, bit-reversed load index
bfly_en  output  1  issue one butterfly this cycle
stage  output  2  current stage index, 0..3
bfly_idx  output  3  butterfly index within the stage, 0..7
bfly_wb_en  output  1  butterfly result write-back strobe
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts the output sample
rd_addr  output  4  buffer read address for output, natural order
out_last  output  1  marks output sample 15
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse after the last output handshake

Behaviour:
- States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD. All state and counters are registered.
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters=0.
  - in_ready, wr_en, bfly_en, bfly_wb_en, out_valid, out_last, busy and frame_done all =0.
  - wr_addr, stage, bfly_idx and rd_addr all =0.
  - The write-back delay line is cleared.
  - Reset mid-frame abandons the frame; no further strobes are issued.
- IDLE: in_ready=0. If in_valid=1, move to LOAD on the next edge; the sample is not consumed in IDLE.
- LOAD:
  - in_ready=1. wr_en = in_valid & in_ready (combinational).
  - wr_addr = bit-reverse(load_cnt), so count 1 gives 8 and count 3 gives 12.
  - load_cnt increments on each accepted beat and wraps 15 to 0.
  - The beat accepted at load_cnt=15 moves the FSM to COMPUTE; in_ready drops the following cycle.
  - Gaps in in_valid stall the load with no timeout.
- COMPUTE:
  - bfly_en=1 every cycle; bfly_idx counts 0..7 and stage holds.
  - After bfly_idx=7, move to DRAIN.
- DRAIN:
  - bfly_en=0 for BFLY_LAT cycles. This prevents read-after-write hazards across stages.
  - Then stage increments and the FSM returns to COMPUTE with bfly_idx=0.
  - If stage was NUM_STAGES-1, stage returns to 0 and the FSM moves to UNLOAD.
- bfly_wb_en is bfly_en delayed by exactly BFLY_LAT cycles through a shift register, independent of state. It therefore fires during DRAIN.
- COMPUTE+DRAIN total per frame is NUM_STAGES*(BFLY_PER_STAGE+BFLY_LAT) cycles, which is 40 at defaults.
- UNLOAD:
  - out_valid=1; rd_addr = out_cnt, natural order 0..15; out_last=1 when out_cnt=15.
  - out_cnt advances only on out_valid & out_ready. rd_addr and out_last hold while out_ready=0.
  - The handshake on out_cnt=15 moves the FSM to IDLE and pulses frame_done for one cycle, with out_valid=0 that cycle.
- in_valid outside LOAD is ignored; no samples are lost because in_ready=0.
- Back-to-back frames: if in_valid=1 in the IDLE cycle after frame_done, LOAD starts on the next edge. Minimum frame-to-frame overhead is 1 IDLE cycle.
- All counters are 4 bits or narrower with natural wrap; no saturation is needed.

Optional Feature:
IFFT_OVERRUN_EN
- Defined: adds output port overrun (1 bit).
  - overrun is set when in_valid=1 while the state is COMPUTE, DRAIN or UNLOAD.
  - It is sticky until the FSM enters LOAD; it clears on that transition edge.
  - Reset value is 0.
- Not defined: the port and its logic are absent; in_valid outside LOAD is silently ignored.

Test Plan:
- Reset mid-UNLOAD at out_cnt=5 -> all outputs 0 immediately (asynchronous); after release with in_valid=1, LOAD restarts with wr_addr=0.
- 16 consecutive in_valid beats -> wr_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; in_ready low the cycle after beat 16.
- Default BFLY_LAT=2 -> exactly 32 bfly_en pulses over 40 cycles, stage 0..3, bfly_idx 0..7 each; 32 bfly_wb_en pulses each lagging by 2 cycles.
- UNLOAD with out_ready toggling 1,0,1,0 -> rd_addr advances only on handshake; out_last with rd_addr=15; frame_done one cycle after the final handshake; 16 handshakes total.
- in_valid held high through the whole frame -> next LOAD starts after exactly 1 IDLE cycle; with IFFT_OVERRUN_EN, overrun=1 during COMPUTE and cleared on entry to LOAD.
- BFLY_LAT=5 build -> COMPUTE+DRAIN spans 52 cycles; no bfly_en during any DRAIN window.
